// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM state and captured-operation encodings.
package data_mem_responder_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_DEPTH_LOG = 8;
    localparam int DEF_LATENCY   = 4;
    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_W         = 4;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word storage behind the responder: synchronous write, asynchronous read.
module mem_array #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH_LOG = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_q [2**DEPTH_LOG];

    // NOTE: storage arrays carry no reset; clearing every word would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one LWD/SWD access at a time and completes it a fixed LATENCY later.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int DEPTH_LOG = DEF_DEPTH_LOG,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_read,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 req_err,
    output logic [WORD_SIZE-1:0] acc_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_e           state_q, state_d;
    mem_op_e              op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH_LOG-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;

    logic                 arr_we;
    logic [WORD_SIZE-1:0] arr_rdata;
    logic                 req_any;

    // Upper address bits alias onto the stored words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WORD_SIZE-1:DEPTH_LOG];

    assign req_any = req_read | req_write;

    mem_array #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH_LOG(DEPTH_LOG)
    ) u_mem_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(addr_q),
        .wdata(wdata_q),
        .raddr(addr_q),
        .rdata(arr_rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        acc_d        = acc_q;
        arr_we       = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (req_any) begin
                    op_d    = req_write ? OP_WRITE : OP_READ;
                    addr_d  = req_addr[DEPTH_LOG-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = MEM_WAIT;
                    if (req_read && req_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) begin
                    arr_we       = (op_q == OP_WRITE);
                    if (op_q == OP_READ) begin
                        rdata_d = arr_rdata;
                    end
                    resp_valid_d = 1'b1;
                    acc_d        = acc_q + 1'b1;
                    state_d      = MEM_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= MEM_IDLE;
            op_q         <= OP_READ;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            acc_q        <= acc_d;
        end
    end

    assign req_ready  = (state_q == MEM_IDLE);
    assign busy       = (state_q != MEM_IDLE) | req_any;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign req_err    = err_q;
    assign acc_count  = acc_q;

endmodule
